// File: rtl/audio_pkg.sv
// Shared state type and default widths for the WM8731 I2S master path.
`timescale 1ns/1ps
package audio_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } i2s_state_t;

    localparam int AUD_SAMPLE_W    = 24;
    localparam int AUD_BITS_PER_CH = 32;
endpackage

// File: rtl/audio_bclk_div.sv
// BCLK divider: toggles the bit clock every BCLK_HALF cycles while running and
// flags the clk edge on which the bit clock rises or falls.
`timescale 1ns/1ps
module audio_bclk_div #(
    parameter int BCLK_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bclk,
    output logic rise,
    output logic fall
);
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             wrap;

    always_comb begin
        wrap      = run && (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        if (!run) begin
            div_cnt_d = '0;
            bclk_d    = 1'b0;
        end else if (wrap) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    // Strobes are valid in the cycle whose closing edge changes bclk.
    assign bclk = bclk_q;
    assign rise = wrap && !bclk_q;
    assign fall = wrap && bclk_q;
endmodule

// File: rtl/audio_i2s_master.sv
// I2S BCLK/LRCK master for the WM8731 plus ADCDAT capture into parallel
// left/right samples with a frame counter for the fabric monitor tap.
`timescale 1ns/1ps
module audio_i2s_master
    import audio_pkg::*;
#(
    parameter int BCLK_HALF   = 2,
    parameter int BITS_PER_CH = AUD_BITS_PER_CH,
    parameter int SAMPLE_W    = AUD_SAMPLE_W,
    parameter int FCNT_W      = 16
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                enable,
    input  logic                aud_adcdat,
    output logic                aud_bclk,
    output logic                aud_lrck,
    output logic                busy,
    output logic [SAMPLE_W-1:0] adc_left,
    output logic [SAMPLE_W-1:0] adc_right,
    output logic                adc_valid,
    output logic [FCNT_W-1:0]   frame_cnt
);
    localparam int BC_W = $clog2(2 * BITS_PER_CH);
    localparam logic [BC_W-1:0] BIT_LAST    = BC_W'(2 * BITS_PER_CH - 1);
    localparam logic [BC_W-1:0] RIGHT_FIRST = BC_W'(BITS_PER_CH);
    localparam logic [BC_W-1:0] SLOT_LAST   = BC_W'(SAMPLE_W);

    i2s_state_t          state_q, state_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                lrck_q, lrck_d;
    logic [SAMPLE_W-1:0] sr_left_q, sr_left_d, sr_right_q, sr_right_d;
    logic [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
    logic                valid_q, valid_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

    logic            run, rise, fall, is_right, in_window;
    logic [BC_W-1:0] slot;

    assign run = (state_q != IDLE);

    audio_bclk_div #(.BCLK_HALF(BCLK_HALF)) u_div (
        .clk  (clk_clk),
        .rst  (reset_reset),
        .run  (run),
        .bclk (aud_bclk),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        is_right   = (bit_cnt_q >= RIGHT_FIRST);
        slot       = is_right ? (bit_cnt_q - RIGHT_FIRST) : bit_cnt_q;
        in_window  = (slot != '0) && (slot <= SLOT_LAST);

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sr_left_d  = sr_left_q;
        sr_right_d = sr_right_q;
        left_d     = left_q;
        right_d    = right_q;
        valid_d    = 1'b0;
        fcnt_d     = fcnt_q;

        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable)
                    state_d = RUN;
                else if (fall && (bit_cnt_q == BIT_LAST))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fall)
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;

        // I2S: MSB in slot 1, so slots 1..SAMPLE_W carry data.
        if (rise && in_window) begin
            if (is_right) begin
                sr_right_d = {sr_right_q[SAMPLE_W-2:0], aud_adcdat};
                if (slot == SLOT_LAST) begin
                    left_d  = sr_left_q;
                    right_d = {sr_right_q[SAMPLE_W-2:0], aud_adcdat};
                    valid_d = 1'b1;
                    fcnt_d  = fcnt_q + 1'b1;
                end
            end else begin
                sr_left_d = {sr_left_q[SAMPLE_W-2:0], aud_adcdat};
            end
        end

        if (state_d == IDLE) begin
            bit_cnt_d  = '0;
            sr_left_d  = '0;
            sr_right_d = '0;
        end

        // Follows bit_cnt one clk later, forced low as soon as we go idle.
        lrck_d = (state_d != IDLE) && is_right;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            lrck_q     <= 1'b0;
            sr_left_q  <= '0;
            sr_right_q <= '0;
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            lrck_q     <= lrck_d;
            sr_left_q  <= sr_left_d;
            sr_right_q <= sr_right_d;
            left_q     <= left_d;
            right_q    <= right_d;
            valid_q    <= valid_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign aud_lrck  = lrck_q;
    assign busy      = run;
    assign adc_left  = left_q;
    assign adc_right = right_q;
    assign adc_valid = valid_q;
    assign frame_cnt = fcnt_q;
endmodule

// File: tb/tb_audio_i2s_master.sv
// Randomized bench for audio_i2s_master: an I2S codec model feeds ADCDAT and a
// timeline-based reference model predicts every output on every cycle.
`timescale 1ns/1ps
module tb_audio_i2s_master;
    localparam int H     = 2;
    localparam int BPC   = 32;
    localparam int SW    = 24;
    localparam int FW    = 4;
    localparam int FRAME = 2 * H * 2 * BPC;

    logic          clk = 1'b0;
    logic          reset_reset = 1'b1;
    logic          enable = 1'b0;
    logic          aud_adcdat = 1'b0;
    logic          aud_bclk, aud_lrck, busy, adc_valid;
    logic [SW-1:0] adc_left, adc_right;
    logic [FW-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    audio_i2s_master #(
        .BCLK_HALF(H), .BITS_PER_CH(BPC), .SAMPLE_W(SW), .FCNT_W(FW)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (reset_reset),
        .enable      (enable),
        .aud_adcdat  (aud_adcdat),
        .aud_bclk    (aud_bclk),
        .aud_lrck    (aud_lrck),
        .busy        (busy),
        .adc_left    (adc_left),
        .adc_right   (adc_right),
        .adc_valid   (adc_valid),
        .frame_cnt   (frame_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- codec model: launches data after each BCLK fall ----------------
    logic [SW-1:0] q_l[$];
    logic [SW-1:0] q_r[$];
    logic [SW-1:0] cur_l = '0, cur_r = '0;
    logic          lrck_prev = 1'b0, bclk_prev = 1'b0;
    int            k = 0;
    bit            fixed_mode = 1'b0;

    always @(negedge clk) begin
        if (reset_reset || !busy) begin
            k         = 0;
            lrck_prev = 1'b0;
            aud_adcdat = 1'($urandom_range(0, 1));
        end else if (bclk_prev && !aud_bclk) begin
            if (aud_lrck != lrck_prev) k = 1;
            else k++;
            lrck_prev = aud_lrck;
            if (k == 1 && !aud_lrck) begin
                if (fixed_mode) begin
                    cur_l = 24'hA5A5A5;
                    cur_r = 24'h5A5A5A;
                end else begin
                    cur_l = SW'($urandom);
                    cur_r = SW'($urandom);
                end
                q_l.push_back(cur_l);
                q_r.push_back(cur_r);
            end
            if (k >= 1 && k <= SW)
                aud_adcdat = aud_lrck ? cur_r[SW-k] : cur_l[SW-k];
            else
                aud_adcdat = 1'($urandom_range(0, 1));
        end
        bclk_prev = aud_bclk;
    end

    // ---------------- reference model: position p in clk cycles since start ----------------
    int            p = 0;
    bit            running = 1'b0, draining = 1'b0, m_rise = 1'b0;
    int            m_slot = 0;
    logic          exp_bclk = 1'b0, exp_lrck = 1'b0, exp_busy = 1'b0, exp_valid = 1'b0;
    logic [SW-1:0] exp_l = '0, exp_r = '0;
    logic [FW-1:0] exp_fc = '0;

    always @(posedge clk or posedge reset_reset) begin
        if (reset_reset) begin
            p = 0; running = 1'b0; draining = 1'b0;
            exp_bclk = 1'b0; exp_lrck = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0;
            exp_l = '0; exp_r = '0; exp_fc = '0;
            q_l.delete();
            q_r.delete();
        end else begin
            m_rise = 1'b0;
            m_slot = 0;
            exp_valid = 1'b0;
            if (!running) begin
                if (enable) begin
                    running = 1'b1; draining = 1'b0; p = 0;
                end
            end else begin
                p++;
                m_rise = (p % (2 * H)) == H;
                m_slot = (p / (2 * H)) % (2 * BPC);
                if (draining && !enable && (p % FRAME) == 0) begin
                    running = 1'b0; p = 0;
                end else begin
                    draining = !enable;
                end
            end
            if (m_rise && m_slot == BPC + SW) begin
                if (q_l.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL model_queue: sample completed with no word sent (t=%0t)", $time);
                end else begin
                    exp_l = q_l.pop_front();
                    exp_r = q_r.pop_front();
                    exp_fc = exp_fc + 1'b1;
                    exp_valid = 1'b1;
                end
            end
            exp_busy = running;
            exp_bclk = running && ((p / H) % 2 == 1);
            exp_lrck = running && (p >= 1) && ((((p - 1) / (2 * H)) % (2 * BPC)) >= BPC);
        end
    end

    always @(negedge clk) begin
        check("bclk",      32'(aud_bclk),  32'(exp_bclk));
        check("lrck",      32'(aud_lrck),  32'(exp_lrck));
        check("busy",      32'(busy),      32'(exp_busy));
        check("adc_valid", 32'(adc_valid), 32'(exp_valid));
        check("adc_left",  32'(adc_left),  32'(exp_l));
        check("adc_right", 32'(adc_right), 32'(exp_r));
        check("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    end

    // ---------------- bounded wait helpers ----------------
    task automatic wait_valid(input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (adc_valid) begin ok = 1'b1; break; end
        end
        check("wait_valid", 32'(ok), 32'd1);
    endtask

    task automatic wait_lrck(input logic level, input int limit);
        bit   ok = 1'b0;
        logic prev = aud_lrck;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (prev !== level && aud_lrck === level) begin ok = 1'b1; break; end
            prev = aud_lrck;
        end
        check("wait_lrck", 32'(ok), 32'd1);
    endtask

    task automatic wait_bclk_falls(input int n);
        int   seen = 0;
        logic prev = aud_bclk;
        for (int i = 0; i < n * 2 * H + 20 && seen < n; i++) begin
            @(negedge clk);
            if (prev && !aud_bclk) seen++;
            prev = aud_bclk;
        end
        check("wait_bclk_falls", 32'(seen), 32'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bclk"},  32'(aud_bclk),  32'd0);
        check({tag, "_lrck"},  32'(aud_lrck),  32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_valid"}, 32'(adc_valid), 32'd0);
        check({tag, "_left"},  32'(adc_left),  32'd0);
        check({tag, "_right"}, 32'(adc_right), 32'd0);
        check({tag, "_fcnt"},  32'(frame_cnt), 32'd0);
    endtask

    initial begin
        int t_first, t_rise1, t_rise2, nv, drops;
        bit idle_seen;
        logic prev;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_reset = 1'b0;
        repeat (2) @(negedge clk);

        // Start with fixed codec words; measure BCLK latency and period
        fixed_mode = 1'b1;
        enable = 1'b1;
        t_first = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            t_first++;
            if (aud_bclk) break;
        end
        check("bclk_first_rise", 32'(t_first), 32'(H + 1));
        t_rise1 = cyc;
        prev = aud_bclk;
        t_rise2 = t_rise1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!prev && aud_bclk) begin t_rise2 = cyc; break; end
            prev = aud_bclk;
        end
        check("bclk_period", 32'(t_rise2 - t_rise1), 32'(2 * H));

        wait_valid(FRAME + 20);
        $display("frame: left=0x%06h right=0x%06h frame_cnt=%0d", adc_left, adc_right, frame_cnt);
        check("fixed_left",  32'(adc_left),  32'hA5A5A5);
        check("fixed_right", 32'(adc_right), 32'h5A5A5A);
        check("fixed_fcnt",  32'(frame_cnt), 32'd1);

        wait_lrck(1'b1, FRAME + 20);
        t_rise1 = cyc;
        wait_lrck(1'b1, FRAME + 20);
        check("lrck_period", 32'(cyc - t_rise1), 32'(FRAME));

        // Random sample stream
        fixed_mode = 1'b0;
        for (int f = 0; f < 4; f++) begin
            wait_valid(FRAME + 20);
            $display("frame: left=0x%06h right=0x%06h frame_cnt=%0d", adc_left, adc_right, frame_cnt);
        end

        // Drop enable at bit_cnt 10: frame completes, one final valid, then idle
        wait_lrck(1'b0, FRAME + 20);
        wait_bclk_falls(10);
        enable = 1'b0;
        nv = 0;
        idle_seen = 1'b0;
        for (int i = 0; i < FRAME + 40; i++) begin
            @(negedge clk);
            if (adc_valid) nv++;
            if (!busy) begin idle_seen = 1'b1; break; end
        end
        check("drain_idle",   32'(idle_seen), 32'd1);
        check("drain_valids", 32'(nv),        32'd1);
        check("idle_bclk",    32'(aud_bclk),  32'd0);
        check("idle_lrck",    32'(aud_lrck),  32'd0);
        check("idle_busy",    32'(busy),      32'd0);
        repeat (10) @(negedge clk);

        // Reassert enable during DRAIN: no break in the clocks
        enable = 1'b1;
        wait_valid(FRAME + 20);
        repeat (40) @(negedge clk);
        enable = 1'b0;
        drops = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) drops++;
        end
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_valid(FRAME + 20);
            $display("frame: left=0x%06h right=0x%06h frame_cnt=%0d", adc_left, adc_right, frame_cnt);
        end
        check("redrain_busy_drops", 32'(drops), 32'd0);

        // Reset at right slot 12: outputs clear at once, clean frame afterwards
        wait_lrck(1'b1, FRAME + 20);
        wait_bclk_falls(12);
        #2 reset_reset = 1'b1;
        #1 check_all_zero("async_reset");
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (adc_valid) nv++;
        end
        check("reset_no_valid", 32'(nv), 32'd0);
        #2 reset_reset = 1'b0;
        wait_valid(FRAME + 20);
        check("post_reset_fcnt", 32'(frame_cnt), 32'd1);

        // Frame counter wrap with a 4-bit counter
        @(negedge clk);
        #2 reset_reset = 1'b1;
        @(negedge clk);
        #2 reset_reset = 1'b0;
        for (int f = 1; f <= 17; f++) begin
            wait_valid(FRAME + 20);
            if (f == 15) check("fcnt_15", 32'(frame_cnt), 32'd15);
            if (f == 16) check("fcnt_wrap0", 32'(frame_cnt), 32'd0);
        end
        check("fcnt_after_17", 32'(frame_cnt), 32'd1);
        enable = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
